cache_fill_fsm: RTL

Miss-handling controller for the 2-way, 64-set instruction/data caches. On a lookup miss it latches the block address and selects the victim way from the per-set LRU outputs. It then streams eight word requests to the 4-cycle pipelined memory and writes each returned word into the data array. To finish, it commits the tag and marks the filled way most-recently-used by driving the LRU array's write enable, block select and set enable directly.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/onehot_dec.sv | 15 +
 rtl/cache_fill_fsm.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: address field widths, fill FSM state encoding and index/tag helpers.
package cache_pkg;

  localparam int OFFSET_W      = 4;
  localparam int INDEX_W       = 6;
  localparam int TAG_W         = 6;
  localparam int WORDS_PER_BLK = 8;
  localparam int ADDR_BITS     = OFFSET_W + INDEX_W + TAG_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } fill_state_t;

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_BITS-1:0] addr);
    return INDEX_W'(addr >> OFFSET_W);
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_BITS-1:0] addr);
    return TAG_W'(addr >> (OFFSET_W + INDEX_W));
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary to one-hot decoder, N select bits to 2**N outputs.
// Latency: combinational; backpressure: none.
module onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]      sel,
  output logic [(1<<N)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: latches block/victim, streams 8 word reads, writes data, commits tag + LRU.
// Latency: 13 busy cycles at memory latency 4; no backpressure. FILL_MISS_CNT_EN adds a saturating miss_count.
module cache_fill_fsm #(
  parameter int ADDR_W        = 16,
  parameter int WORD_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int SETS          = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_addr,
  input  logic                     block0_isLRU,
  input  logic                     block1_isLRU,
  input  logic                     mem_data_valid,
  input  logic [WORD_W-1:0]        mem_data,
  output logic                     fsm_busy,
  output logic [SETS-1:0]          set_enable,
  output logic                     lru_write_en,
  output logic                     lru_block,
  output logic                     data_write_en,
  output logic [WORDS_PER_BLK-1:0] data_word_en,
  output logic                     data_way,
  output logic [WORD_W-1:0]        data_out,
  output logic                     tag_write_en,
  output logic                     tag_way,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
`ifdef FILL_MISS_CNT_EN
  output logic                     fill_done,
  output logic [15:0]              miss_count
`else
  output logic                     fill_done
`endif
);

  import cache_pkg::*;

  localparam int WIDX_W = $clog2(WORDS_PER_BLK);
  localparam int CNT_W  = WIDX_W + 1;
  localparam int SET_W  = $clog2(SETS);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic              victim_q;
  logic [CNT_W-1:0]  rq_q, rx_q;
  logic [SET_W-1:0]  set_sel;
  logic              victim_d;

  // Way 0 is the victim unless only way 1 reports LRU.
  assign victim_d = block1_isLRU & ~block0_isLRU;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      victim_q <= 1'b0;
      rq_q     <= '0;
      rx_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            base_q   <= miss_addr & ~ADDR_W'((1 << OFFSET_W) - 1);
            victim_q <= victim_d;
            rq_q     <= '0;
            rx_q     <= '0;
          end
        end
        FILL: begin
          if (!rq_q[CNT_W-1]) rq_q <= rq_q + CNT_W'(1);
          if (mem_data_valid) rx_q <= rx_q + CNT_W'(1);
        end
        COMMIT: begin
          rq_q <= '0;
          rx_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_detected) state_d = FILL;
      FILL:    if (mem_data_valid && rx_q == CNT_W'(WORDS_PER_BLK - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  onehot_dec #(.N(SET_W)) u_set_dec (
    .sel    (set_sel),
    .onehot (set_enable)
  );

  logic [WORDS_PER_BLK-1:0] word_dec;

  onehot_dec #(.N(WIDX_W)) u_word_dec (
    .sel    (rx_q[WIDX_W-1:0]),
    .onehot (word_dec)
  );

  always_comb begin
    fsm_busy      = (state_q != IDLE);
    // Outside a fill the LRU array must see the incoming miss's set.
    set_sel       = fsm_busy ? SET_W'(get_index(base_q)) : SET_W'(get_index(miss_addr));
    mem_req       = 1'b0;
    mem_addr      = '0;
    data_write_en = 1'b0;
    data_word_en  = '0;
    data_way      = 1'b0;
    data_out      = '0;
    tag_write_en  = 1'b0;
    tag_way       = 1'b0;
    lru_write_en  = 1'b0;
    lru_block     = 1'b0;
    fill_done     = 1'b0;
    case (state_q)
      FILL: begin
        if (!rq_q[CNT_W-1]) begin
          mem_req  = 1'b1;
          mem_addr = base_q + ADDR_W'({rq_q, 1'b0});
        end
        if (mem_data_valid) begin
          data_write_en = 1'b1;
          data_word_en  = word_dec;
          data_way      = victim_q;
          data_out      = mem_data;
        end
      end
      COMMIT: begin
        tag_write_en = 1'b1;
        tag_way      = victim_q;
        lru_write_en = 1'b1;
        lru_block    = victim_q;
        fill_done    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FILL_MISS_CNT_EN
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_cnt_q <= '0;
    end else if (fill_done && miss_cnt_q != 16'hFFFF) begin
      miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign miss_count = miss_cnt_q;
`endif

endmodule
